// File: rtl/prio_irq_encoder.sv
// Registered N-input priority encoder with pending latch, per-input mask and ack handshake.
// Define ROTATE_PRIO_EN for round-robin priority; the default build uses fixed priority with index N-1 highest.
module prio_irq_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             ack,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  output logic [N-1:0]     pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Handshake: out_valid high means out_idx is offered; a transfer happens on any
  // edge where out_valid && ack. out_idx is frozen until then or until its mask bit drops.
  state_t           state;
  state_t           state_d;
  logic [N-1:0]     elig;
  logic [N-1:0]     clr;
  logic [N-1:0]     pending_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             take_ack;
  logic             withdraw;

  assign elig     = pending & mask;
  assign take_ack = (state == GRANT) && ack;
  assign withdraw = (state == GRANT) && !ack && !mask[out_idx];

`ifdef ROTATE_PRIO_EN
  logic [IDX_W-1:0] ptr;

  // Later assignments override earlier ones, so the search start (ptr) is visited last.
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + N - k) % N]) winner = IDX_W'((int'(ptr) + N - k) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(N - 1);
    end else if (take_ack) begin
      ptr <= (out_idx == '0) ? IDX_W'(N - 1) : out_idx - IDX_W'(1);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) winner = IDX_W'(i);
    end
  end
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_idx   <= '0;
      out_valid <= 1'b0;
      pending   <= '0;
    end else begin
      state     <= state_d;
      out_idx   <= idx_d;
      out_valid <= valid_d;
      pending   <= pending_d;
    end
  end

  // Next-state logic; RECOVER is a one-cycle bubble after every ack.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|elig) state_d = GRANT;
      GRANT: begin
        if (take_ack)      state_d = RECOVER;
        else if (withdraw) state_d = IDLE;
      end
      RECOVER: state_d = (|elig) ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; a set on the same edge as the ack clear keeps the bit.
  always_comb begin
    clr = '0;
    if (take_ack) clr[out_idx] = 1'b1;
    pending_d = (pending & ~clr) | req;
    valid_d   = (state_d == GRANT);
    idx_d     = out_idx;
    if (state != GRANT && state_d == GRANT) idx_d = winner;
  end

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Self-checking bench for prio_irq_encoder: directed scenarios plus random traffic against a transaction-level model.
// Build with ROTATE_PRIO_EN defined to check the round-robin variant.
module tb_prio_irq_encoder;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     mask = '1;
  logic             ack = 1'b0;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic [N-1:0]     pending;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  prio_irq_encoder #(.N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .pending   (pending)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Grant bookkeeping only: a pending set, whether a grant is offered, and which index.
  // An ack makes the offer vanish for one edge; a fresh winner is picked whenever none is offered.
  typedef struct packed {
    logic [N-1:0]     pend;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ptr;
  } model_t;

  localparam model_t M_RESET = '{pend: '0, valid: 1'b0, idx: '0, ptr: IDX_W'(N - 1)};

  model_t m;

  function automatic logic [IDX_W-1:0] pick(logic [N-1:0] e, logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] r = '0;
    bit f = 1'b0;
`ifdef ROTATE_PRIO_EN
    for (int k = 0; k < N; k++) begin
      int i = (int'(p) + N - k) % N;
      if (!f && e[i]) begin r = IDX_W'(i); f = 1'b1; end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (!f && e[i]) begin r = IDX_W'(i); f = 1'b1; end
    end
`endif
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic [N-1:0] rq, logic [N-1:0] mk, logic ak);
    model_t n = c;
    n.pend = c.pend | rq;
    if (c.valid) begin
      if (ak) begin
        n.pend  = (c.pend & ~(N'(1) << c.idx)) | rq;
        n.valid = 1'b0;
        n.ptr   = (c.idx == 0) ? IDX_W'(N - 1) : c.idx - IDX_W'(1);
      end else if (!mk[c.idx]) begin
        n.valid = 1'b0;
      end
    end else if ((c.pend & mk) != 0) begin
      n.valid = 1'b1;
      n.idx   = pick(c.pend & mk, c.ptr);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RESET;
    else        m <= model_next(m, req, mask, ack);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_pending", 32'(pending), 32'(m.pend));
      check("cmp_valid", 32'(out_valid), 32'(m.valid));
      check("cmp_idx", 32'(out_idx), 32'(m.idx));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; ack = 1'b0; mask = '1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    int t = 0;
    while (!out_valid && t < 12) begin tick(); t++; end
    check(name, 32'(out_valid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    run_cmp = 1'b1;

    // Reset with all requests high, then release.
    req = 8'hFF; mask = 8'hFF; ack = 1'b0; rst_n = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_pending", 32'(pending), 32'hFF);
    check("rel_valid", 32'(out_valid), 32'd0);
    tick();
    check("rel_grant_idx", 32'(out_idx), 32'd7);

    // Single-cycle pulse on two inputs.
    do_reset();
    req = 8'h24; tick(); req = '0;
    check("pulse_pending", 32'(pending), 32'h24);
    check("pulse_valid0", 32'(out_valid), 32'd0);
    tick();
    check("pulse_valid1", 32'(out_valid), 32'd1);
    check("pulse_idx5", 32'(out_idx), 32'd5);
    ack = 1'b1; tick(); ack = 1'b0;
    check("pulse_ack_valid", 32'(out_valid), 32'd0);
    check("pulse_ack_pending", 32'(pending), 32'h04);
    tick();
    check("pulse_idx2", 32'(out_idx), 32'd2);
    check("pulse_valid2", 32'(out_valid), 32'd1);

    // Mask, then no pre-emption by a newly eligible higher input.
    do_reset();
    mask = 8'h7F; req = 8'h81; tick(); req = '0;
    tick();
    check("mask_idx0", 32'(out_idx), 32'd0);
    mask = 8'hFF; tick();
    check("freeze_idx0", 32'(out_idx), 32'd0);
    check("freeze_valid", 32'(out_valid), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("freeze_recover", 32'(out_valid), 32'd0);
    tick();
    check("freeze_idx7", 32'(out_idx), 32'd7);

    // Withdraw by mask drop, then re-grant.
    do_reset();
    req = 8'h08; tick(); req = '0; tick();
    check("wd_idx3", 32'(out_idx), 32'd3);
    mask = 8'hF7; tick();
    check("wd_valid", 32'(out_valid), 32'd0);
    check("wd_pending", 32'(pending), 32'h08);
    tick();
    check("wd_hold", 32'(out_valid), 32'd0);
    mask = 8'hFF; tick();
    check("wd_regrant_valid", 32'(out_valid), 32'd1);
    check("wd_regrant_idx", 32'(out_idx), 32'd3);

    // Collision: ack with a fresh request on the granted bit.
    ack = 1'b1; req = 8'h08; tick(); req = '0; ack = 1'b0;
    check("col_pending", 32'(pending), 32'h08);
    check("col_recover", 32'(out_valid), 32'd0);
    tick();
    check("col_regrant", 32'(out_idx), 32'd3);
    ack = 1'b1; tick();
    check("col_clear", 32'(pending), 32'h00);
    tick(); tick();   // ack held through RECOVER and IDLE
    ack = 1'b0;
    check("ign_valid", 32'(out_valid), 32'd0);
    check("ign_pending", 32'(pending), 32'h00);

    // Arbitration with all requests held.
    do_reset();
    req = 8'hFF; tick();
    for (int g = 0; g < 9; g++) begin
      wait_grant("arb_grant_seen");
`ifdef ROTATE_PRIO_EN
      check("arb_idx", 32'(out_idx), 32'((7 - g + 8) % 8));
`else
      check("arb_idx", 32'(out_idx), 32'd7);
`endif
      ack = 1'b1; tick(); ack = 1'b0;
    end

    // Asynchronous reset mid-GRANT.
    wait_grant("async_grant_seen");
    rst_n = 1'b0; #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_idx", 32'(out_idx), 32'd0);
    check("async_pending", 32'(pending), 32'd0);
    tick();
    rst_n = 1'b1;
    req = '0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : '0;
      mask = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      ack  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
